// File: rtl/demux2_stream.sv
// demux2_stream: routes one input stream into two independent channels.
// Each channel owns a 2-entry register FIFO and a push counter; the input
// handshake looks only at the FIFO currently selected by s.

// Per-channel 2-entry in-order FIFO with occupancy FSM and push counter.
module demux2_stream_chan #(
   parameter int WIDTH = 8,
   parameter int CNTW  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] d,
   input  logic             ready,
   output logic             full,
   output logic             valid,
   output logic [WIDTH-1:0] y,
   output logic [CNTW-1:0]  cnt
);

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_t;

   occ_t             occ;
   logic [WIDTH-1:0] head;
   logic [WIDTH-1:0] tail;
   logic             pop;

   // Valid/full come straight from the registered occupancy, so there is
   // never a combinational path from d to y.
   assign valid = (occ != EMPTY);
   assign full  = (occ == FULL);
   assign pop   = valid & ready;
   assign y     = head;

   // Occupancy FSM; head is kept at zero whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         occ  <= EMPTY;
         head <= '0;
         tail <= '0;
      end else begin
         case (occ)
            EMPTY: begin
               if (push) begin
                  occ  <= ONE;
                  head <= d;
               end
            end
            ONE: begin
               if (push && pop) begin
                  head <= d;
               end else if (push) begin
                  occ  <= FULL;
                  tail <= d;
               end else if (pop) begin
                  occ  <= EMPTY;
                  head <= '0;
               end
            end
            FULL: begin
               // A push is never accepted here, even if popped this cycle.
               if (pop) begin
                  occ  <= ONE;
                  head <= tail;
                  tail <= '0;
               end
            end
            default: begin
               occ  <= EMPTY;
               head <= '0;
               tail <= '0;
            end
         endcase
      end
   end

   // Push counter, wraps naturally at 2^CNTW; pops do not affect it.
   always_ff @(posedge clk) begin
      if (!rst_n)    cnt <= '0;
      else if (push) cnt <= cnt + CNTW'(1);
   end

endmodule

// Top: select-driven demux in front of two channel FIFOs.
module demux2_stream #(
   parameter int WIDTH = 8,
   parameter int CNTW  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   input  logic             s,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] y0,
   output logic             y0_valid,
   input  logic             y0_ready,
   output logic [WIDTH-1:0] y1,
   output logic             y1_valid,
   input  logic             y1_ready,
   output logic [CNTW-1:0]  cnt0,
   output logic [CNTW-1:0]  cnt1
);

   localparam int NUM_CH = 2;

   logic [NUM_CH-1:0]            sel;
   logic [NUM_CH-1:0]            push;
   logic [NUM_CH-1:0]            full;
   logic [NUM_CH-1:0]            valid;
   logic [NUM_CH-1:0]            ready;
   logic [NUM_CH-1:0][WIDTH-1:0] y;
   logic [NUM_CH-1:0][CNTW-1:0]  cnt;

   // in_ready tracks only the selected FIFO, so changing s re-evaluates it
   // in the same cycle; consumer readies are deliberately not involved.
   assign sel      = {s, ~s};
   assign in_ready = ~full[s];
   assign push     = sel & {NUM_CH{in_valid & in_ready}};
   assign ready    = {y1_ready, y0_ready};

   genvar k;
   generate
      for (k = 0; k < NUM_CH; k++) begin : g_ch
         demux2_stream_chan #(.WIDTH(WIDTH), .CNTW(CNTW)) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[k]),
            .d     (d),
            .ready (ready[k]),
            .full  (full[k]),
            .valid (valid[k]),
            .y     (y[k]),
            .cnt   (cnt[k])
         );
      end
   endgenerate

   assign y0       = y[0];
   assign y1       = y[1];
   assign y0_valid = valid[0];
   assign y1_valid = valid[1];
   assign cnt0     = cnt[0];
   assign cnt1     = cnt[1];

endmodule

// File: tb/tb_demux2_stream.sv
// Self-checking bench for demux2_stream: directed scenarios plus a random
// run compared against a queue-based model of the two channels.
module tb_demux2_stream;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] d;
   logic       s;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] y0, y1;
   logic       y0_valid, y1_valid;
   logic       y0_ready, y1_ready;
   logic [7:0] cnt0, cnt1;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: one queue per channel plus push counters.
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic [7:0] m_cnt0, m_cnt1;

   demux2_stream #(.WIDTH(8), .CNTW(8)) dut (
      .clk(clk), .rst_n(rst_n), .d(d), .s(s), .in_valid(in_valid),
      .in_ready(in_ready), .y0(y0), .y0_valid(y0_valid), .y0_ready(y0_ready),
      .y1(y1), .y1_valid(y1_valid), .y1_ready(y1_ready),
      .cnt0(cnt0), .cnt1(cnt1)
   );

   always #5 clk = ~clk;

   // One rising edge; model advances from the pre-edge inputs, then settle.
   task automatic tick();
      bit acc, p0, p1;
      acc = in_valid && (s ? (q1.size() < 2) : (q0.size() < 2));
      p0  = y0_ready && (q0.size() > 0);
      p1  = y1_ready && (q1.size() > 0);
      @(posedge clk);
      if (!rst_n) begin
         q0.delete(); q1.delete();
         m_cnt0 = 8'd0; m_cnt1 = 8'd0;
      end else begin
         if (p0) void'(q0.pop_front());
         if (p1) void'(q1.pop_front());
         if (acc) begin
            if (s) begin q1.push_back(d); m_cnt1++; end
            else   begin q0.push_back(d); m_cnt0++; end
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; in_valid = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic push_one(input logic sel, input logic [7:0] data);
      in_valid = 1'b1; s = sel; d = data;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b1; s = 1'b0; d = 8'hFF;
      y0_ready = 1'b0; y1_ready = 1'b0;
      tick();
      n_chk++;
      if ({y0_valid, y1_valid, y0, y1, cnt0, cnt1} !== 34'd0) begin
         n_fail++;
         $display("FAIL reset_state: got v=%b%b y0=%h y1=%h c0=%h c1=%h want all 0",
                  y0_valid, y1_valid, y0, y1, cnt0, cnt1);
      end
      s = 1'b0; #1;
      n_chk++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_s0: got %b want 1", in_ready); end
      s = 1'b1; #1;
      n_chk++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_s1: got %b want 1", in_ready); end
      rst_n = 1'b1; in_valid = 1'b0;
   endtask

   task automatic test_route_split();
      do_reset();
      y0_ready = 1'b1; y1_ready = 1'b1;
      in_valid = 1'b1; s = 1'b0; d = 8'hCA;
      tick();
      n_chk++;
      if ({y0_valid, y0} !== {1'b1, 8'hCA}) begin
         n_fail++; $display("FAIL route_y0: got v=%b y=%h want v=1 y=ca", y0_valid, y0);
      end
      s = 1'b1; d = 8'h45;
      tick();
      in_valid = 1'b0;
      n_chk++;
      if ({y1_valid, y1, y0_valid} !== {1'b1, 8'h45, 1'b0}) begin
         n_fail++; $display("FAIL route_y1: got v1=%b y1=%h v0=%b want v1=1 y1=45 v0=0", y1_valid, y1, y0_valid);
      end
      n_chk++;
      if ({cnt0, cnt1} !== {8'd1, 8'd1}) begin
         n_fail++; $display("FAIL route_cnt: got %0d/%0d want 1/1", cnt0, cnt1);
      end
      tick();
   endtask

   task automatic test_backpressure();
      do_reset();
      y0_ready = 1'b0; y1_ready = 1'b0;
      push_one(1'b0, 8'h11);
      push_one(1'b0, 8'h22);
      s = 1'b0; #1;
      n_chk++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_s0: got %b want 0", in_ready); end
      s = 1'b1; #1;
      n_chk++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_s1: got %b want 1", in_ready); end
      y0_ready = 1'b1; #1;
      n_chk++;
      if ({y0_valid, y0} !== {1'b1, 8'h11}) begin
         n_fail++; $display("FAIL bp_first: got v=%b y=%h want v=1 y=11", y0_valid, y0);
      end
      tick();
      n_chk++;
      if ({y0_valid, y0} !== {1'b1, 8'h22}) begin
         n_fail++; $display("FAIL bp_second: got v=%b y=%h want v=1 y=22", y0_valid, y0);
      end
      tick();
      n_chk++;
      if ({y0_valid, y0} !== 9'd0) begin
         n_fail++; $display("FAIL bp_drained: got v=%b y=%h want v=0 y=00", y0_valid, y0);
      end
   endtask

   task automatic test_full_pop();
      do_reset();
      y0_ready = 1'b0; y1_ready = 1'b0;
      push_one(1'b1, 8'hA1);
      push_one(1'b1, 8'hA2);
      in_valid = 1'b1; s = 1'b1; d = 8'hA3; y1_ready = 1'b1; #1;
      n_chk++;
      if ({in_ready, y1} !== {1'b0, 8'hA1}) begin
         n_fail++; $display("FAIL fullpop_refuse: got rdy=%b y1=%h want rdy=0 y1=a1", in_ready, y1);
      end
      tick();
      n_chk++;
      if ({y1, cnt1, in_ready} !== {8'hA2, 8'd2, 1'b1}) begin
         n_fail++; $display("FAIL fullpop_second: got y1=%h c1=%0d rdy=%b want a2/2/1", y1, cnt1, in_ready);
      end
      tick();
      in_valid = 1'b0;
      n_chk++;
      if ({y1_valid, y1, cnt1} !== {1'b1, 8'hA3, 8'd3}) begin
         n_fail++; $display("FAIL fullpop_third: got v=%b y1=%h c1=%0d want 1/a3/3", y1_valid, y1, cnt1);
      end
      tick();
   endtask

   task automatic test_one_push_pop();
      do_reset();
      y0_ready = 1'b0; y1_ready = 1'b0;
      push_one(1'b0, 8'h01);
      y0_ready = 1'b1;
      push_one(1'b0, 8'h02);
      n_chk++;
      if ({y0_valid, y0} !== {1'b1, 8'h02}) begin
         n_fail++; $display("FAIL one_pushpop: got v=%b y=%h want v=1 y=02", y0_valid, y0);
      end
      tick();
      n_chk++;
      if (y0_valid !== 1'b0) begin
         n_fail++; $display("FAIL one_occupancy: got v=%b want 0 after single pop", y0_valid);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      y0_ready = 1'b1; y1_ready = 1'b1;
      in_valid = 1'b1; s = 1'b0;
      for (int i = 0; i < 256; i++) begin
         d = 8'(i);
         tick();
      end
      in_valid = 1'b0;
      n_chk++;
      if ({cnt0, cnt1} !== {8'd0, 8'd0}) begin
         n_fail++; $display("FAIL wrap_cnt: got %0d/%0d want 0/0", cnt0, cnt1);
      end
      n_chk++;
      if ({y0_valid, y0} !== {1'b1, 8'hFF}) begin
         n_fail++; $display("FAIL wrap_last: got v=%b y=%h want v=1 y=ff", y0_valid, y0);
      end
      tick();
   endtask

   task automatic test_random();
      logic exp_rdy;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         in_valid = 1'($urandom_range(0, 3) != 0);
         s        = 1'($urandom);
         d        = 8'($urandom);
         y0_ready = 1'($urandom_range(0, 2) == 0);
         y1_ready = 1'($urandom_range(0, 2) != 0);
         #1;
         exp_rdy = s ? (q1.size() < 2) : (q0.size() < 2);
         n_chk++;
         if (in_ready !== exp_rdy) begin
            n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b", i, in_ready, exp_rdy);
         end
         tick();
         n_chk++;
         if ({y0_valid, y0, y1_valid, y1, cnt0, cnt1} !==
             {q0.size() > 0, (q0.size() > 0) ? q0[0] : 8'h00,
              q1.size() > 0, (q1.size() > 0) ? q1[0] : 8'h00, m_cnt0, m_cnt1}) begin
            n_fail++;
            $display("FAIL rand_out[%0d]: got v0=%b y0=%h v1=%b y1=%h c=%0d/%0d want sizes %0d/%0d c=%0d/%0d",
                     i, y0_valid, y0, y1_valid, y1, cnt0, cnt1, q0.size(), q1.size(), m_cnt0, m_cnt1);
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      y0_ready = 1'b0; y1_ready = 1'b0;
      push_one(1'b0, 8'h10); push_one(1'b0, 8'h20);
      push_one(1'b1, 8'h30); push_one(1'b1, 8'h40);
      s = 1'b0; #1;
      n_chk++;
      if ({in_ready, y0_valid, y1_valid} !== 3'b011) begin
         n_fail++; $display("FAIL mid_full: got rdy=%b v=%b%b want 0/11", in_ready, y0_valid, y1_valid);
      end
      rst_n = 1'b0; in_valid = 1'b1; d = 8'h55; y0_ready = 1'b1; y1_ready = 1'b1;
      tick();
      rst_n = 1'b1; in_valid = 1'b0;
      n_chk++;
      if ({y0_valid, y1_valid, y0, y1, cnt0, cnt1} !== 34'd0) begin
         n_fail++;
         $display("FAIL mid_reset: got v=%b%b y0=%h y1=%h c=%0d/%0d want all 0",
                  y0_valid, y1_valid, y0, y1, cnt0, cnt1);
      end
      s = 1'b0; #1;
      n_chk++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_s0: got %b want 1", in_ready); end
      s = 1'b1; #1;
      n_chk++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_s1: got %b want 1", in_ready); end
   endtask

   initial begin
      rst_n = 1'b0; d = 8'h00; s = 1'b0; in_valid = 1'b0;
      y0_ready = 1'b0; y1_ready = 1'b0;
      m_cnt0 = 8'd0; m_cnt1 = 8'd0;
      @(negedge clk);
      test_reset();
      test_route_split();
      test_backpressure();
      test_full_pop();
      test_one_push_pop();
      test_wrap();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/demux2_stream.md
DEMUX2_STREAM -- requirements
Module: demux2_stream

Interface
REQ-001 Parameter WIDTH, default 8: data width of the input and of both outputs.
REQ-002 Parameter CNTW, default 8: width of the per-output transfer counters.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 d  input  WIDTH  input data byte.
REQ-006 s  input  1  route select: 0 sends d to output 0, 1 sends d to output 1.
REQ-007 in_valid  input  1  d/s valid this cycle.
REQ-008 in_ready  output  1  block accepts d this cycle.
REQ-009 y0  output  WIDTH  head data of channel 0 queue.
REQ-010 y0_valid  output  1  y0 holds valid data.
REQ-011 y0_ready  input  1  channel 0 consumer takes y0.
REQ-012 y1  output  WIDTH  head data of channel 1 queue.
REQ-013 y1_valid  output  1  y1 holds valid data.
REQ-014 y1_ready  input  1  channel 1 consumer takes y1.
REQ-015 cnt0  output  CNTW  count of bytes accepted into channel 0.
REQ-016 cnt1  output  CNTW  count of bytes accepted into channel 1.

Function
REQ-017 Each channel SHALL own an independent 2-entry FIFO (register-based, in-order).
REQ-018 Each channel FIFO SHALL have three occupancy states: EMPTY (0), ONE (1), FULL (2).
REQ-019 A push SHALL occur on a rising edge when in_valid=1 and in_ready=1; data goes to the FIFO selected by s.
REQ-020 in_ready SHALL be combinational: 1 when the FIFO selected by s is not FULL, else 0.
REQ-021 in_ready SHALL NOT depend on y0_ready or y1_ready; a FULL FIFO refuses a push even if it is popped in the same cycle.
REQ-022 A pop on channel k SHALL occur on a rising edge when yk_valid=1 and yk_ready=1.
REQ-023 yk_valid SHALL be 1 exactly when FIFO k is not EMPTY; yk SHALL equal the oldest entry.
REQ-024 yk SHALL be 0 when FIFO k is EMPTY.
REQ-025 Latency: a byte pushed at edge N SHALL appear on yk with yk_valid=1 after edge N if FIFO k was EMPTY; there is no combinational d-to-yk path.
REQ-026 Transitions: EMPTY+push -> ONE. ONE+push -> FULL. ONE+pop -> EMPTY. FULL+pop -> ONE. ONE+push+pop -> ONE with the new byte at head. FULL+pop (push refused) -> ONE.
REQ-027 A pop on EMPTY SHALL NOT be possible, because yk_valid=0.
REQ-028 Pushes to one channel and pops on either or both channels in the same cycle SHALL all take effect independently.
REQ-029 The non-selected channel SHALL be unaffected by the push.
REQ-030 cntk SHALL increment by 1 on every push into channel k and wrap from 2^CNTW-1 to 0.
REQ-031 cntk SHALL NOT change on pops.
REQ-032 Changing s while in_valid=1 and in_ready=0 is legal; in_ready SHALL re-evaluate against the newly selected FIFO in the same cycle.

Reset
REQ-033 When rst_n=0 at a rising edge, both FIFOs SHALL go EMPTY and cnt0, cnt1, y0 and y1 SHALL go 0.
REQ-034 Reset SHALL override any simultaneous push or pop.
REQ-035 Bytes held in the FIFOs when reset asserts mid-operation SHALL be discarded.
REQ-036 Once reset has been applied, in_ready SHALL be 1 for either value of s.
REQ-037 Before the first reset edge, output values SHALL be unspecified.

Verification
REQ-038 Route split: after reset, y0_ready=y1_ready=1; push d=8'hCA s=0, then d=8'h45 s=1 -> y0=8'hCA valid one cycle after the first push, y1=8'h45 valid one cycle after the second, cnt0=1, cnt1=1.
REQ-039 Backpressure/full: y0_ready=0; push 8'h11, 8'h22 with s=0 -> in_ready=0 with s=0 and in_ready=1 with s=1; raise y0_ready -> y0 shows 8'h11 then 8'h22, in order.
REQ-040 Full, simultaneous pop: channel 1 FULL (8'hA1, 8'hA2), in_valid=1 s=1 d=8'hA3, y1_ready=1 -> 8'hA3 refused that cycle and accepted the next cycle; y1 order is A1, A2, A3; cnt1=3.
REQ-041 ONE-state push+pop: channel 0 holds 8'h01; push 8'h02 while popping -> y0=8'h02, y0_valid=1, occupancy stays ONE.
REQ-042 Counter wrap: with CNTW=8, push 256 bytes into channel 0 -> cnt0=0; cnt1 unchanged.
REQ-043 Reset mid-operation: both FIFOs FULL, rst_n=0 for one edge together with in_valid=1 -> y0_valid=y1_valid=0, y0=y1=0, cnt0=cnt1=0, in_ready=1 after the edge.
